cnn16_mem_arbiter: RTL and testbench

- Shares the single 16-bit memory port between two requesters: the CNN16 core (requester 0) and the image/weight loader DMA (requester 1).
- Sits between the requesters and the memory.
- Drives the memory-side address, data and write enable, and waits for the memory's mem_ready handshake.
- Returns read data plus a one-cycle ack to the winning requester.
- Arbitration is round-robin. A timeout watchdog prevents a stuck memory from hanging the core.

---
 rtl/cnn16_pkg.sv | 14 +
 rtl/cnn16_rr_pick2.sv | 20 ++
 rtl/cnn16_mem_arbiter.sv | 167 ++++++++++++++++
 tb/tb_cnn16_mem_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn16_pkg.sv
// Shared constants for the CNN16 memory subsystem: word/address widths and
// the arbiter state encoding.
package cnn16_pkg;

    localparam int CNN16_ADDR_W = 12;
    localparam int CNN16_DATA_W = 16;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t ISSUE = 2'd1;
    localparam arb_state_t RESP  = 2'd2;

endpackage

// File: rtl/cnn16_rr_pick2.sv
// Combinational two-way round-robin selector; on a tie the requester that is
// not the pointer wins.
module cnn16_rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic gnt_valid,
    output logic gnt_id
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = ~ptr;
        end else begin
            gnt_id = req1;
        end
    end

endmodule

// File: rtl/cnn16_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CNN16 core (0) and
// the loader DMA (1), with a ready-timeout watchdog. All outputs are registered.
module cnn16_mem_arbiter
    import cnn16_pkg::*;
#(
    parameter int          ADDR_W  = CNN16_ADDR_W,
    parameter int          DATA_W  = CNN16_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic              err0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              owner
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic gnt_valid;
    logic gnt_id;

    cnn16_rr_pick2 u_pick (
        .req0      (req0),
        .req1      (req1),
        .ptr       (ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ack_d       = 2'b00;
        err_d       = 2'b00;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d     = ISSUE;
                    owner_d     = gnt_id;
                    ptr_d       = gnt_id;
                    cnt_d       = 8'd0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = gnt_id ? we1 : we0;
                    mem_addr_d  = gnt_id ? addr1 : addr0;
                    mem_wdata_d = gnt_id ? wdata1 : wdata0;
                end
            end
            ISSUE: begin
                // A ready arriving on the timeout cycle still counts as success.
                if (mem_ready) begin
                    state_d        = RESP;
                    mem_req_d      = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    if (!mem_we_q) begin
                        if (owner_q) rdata1_d = mem_rdata;
                        else         rdata0_d = mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = RESP;
                    mem_req_d      = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    err_d[owner_q] = 1'b1;
                    if (owner_q) rdata1_d = '0;
                    else         rdata0_d = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b1;
            cnt_q       <= 8'd0;
            owner_q     <= 1'b0;
            busy_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack_q       <= 2'b00;
            err_q       <= 2'b00;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            busy_q      <= busy_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign ack0      = ack_q[0];
    assign ack1      = ack_q[1];
    assign err0      = err_q[0];
    assign err1      = err_q[1];
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_cnn16_mem_arbiter.sv
// Bench for cnn16_mem_arbiter: directed reset/latency cases, then random
// two-requester traffic checked against a transaction-timing reference model.
module tb_cnn16_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, err0, ack1, err1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_req, mem_we, mem_ready, busy, owner;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] mem_model [4096];

    always #5 clk = ~clk;

    cnn16_mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .ack0      (ack0),
        .err0      (err0),
        .rdata0    (rdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .ack1      (ack1),
        .err1      (err1),
        .rdata1    (rdata1),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .owner     (owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {24'd0, ack0, err0, ack1, err1, mem_req, mem_we, busy, owner}, 32'd0);
        check({tag, "_rd0"}, rdata0, 32'd0);
        check({tag, "_rd1"}, rdata1, 32'd0);
        check({tag, "_maddr"}, mem_addr, 32'd0);
        check({tag, "_mwdata"}, mem_wdata, 32'd0);
    endtask

    task automatic do_reset();
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic new_req(input bit who);
        if (who) begin
            we1    = 1'($urandom_range(0, 1));
            addr1  = AW'($urandom_range(0, 31));
            wdata1 = DW'($urandom);
        end else begin
            we0    = 1'($urandom_range(0, 1));
            addr0  = AW'($urandom_range(0, 31));
            wdata0 = DW'($urandom);
        end
    endtask

    initial begin
        int cyc, grant_t, done_t, d;
        bit last, win, timed;
        logic s_req0, s_req1, g_we;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_wdata;
        logic [DW-1:0] exp_rd [2];

        for (int i = 0; i < 4096; i++) mem_model[i] = DW'($urandom);

        // Reset values.
        do_reset();
        check_all_zero("reset");

        // Single read, ready in the second ISSUE cycle.
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h0A5;
        tick();
        check("t1_mem_req", mem_req, 1);
        check("t1_mem_addr", mem_addr, 12'h0A5);
        check("t1_mem_we", mem_we, 0);
        tick();
        check("t1_no_ack_yet", ack0, 0);
        mem_ready = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_ready = 1'b0; req0 = 1'b0;
        check("t1_ack0", ack0, 1);
        check("t1_err0", err0, 0);
        check("t1_rdata0", rdata0, 16'h1234);
        check("t1_ack1", ack1, 0);
        check("t1_mem_req_drop", mem_req, 0);
        tick();
        check("t1_ack_once", ack0, 0);
        check("t1_idle", busy, 0);
        check("t1_rdata_held", rdata0, 16'h1234);

        // Stray ready while idle.
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("t6_ack", {ack0, ack1}, 0);
        check("t6_busy", busy, 0);

        // Reset mid-ISSUE, then a tie must go to requester 0.
        req0 = 1'b1; we0 = 1'b0; addr0 = 12'h155;
        tick();
        check("t5_granted", mem_req, 1);
        tick();
        rst = 1'b0;
        #1;
        check_all_zero("t5_async");
        req1 = 1'b1; we1 = 1'b1; addr1 = 12'h3C3;
        tick();
        check("t5_no_ack", {ack0, ack1}, 0);
        rst = 1'b1;
        tick();
        check("t5_tie_owner", owner, 0);
        check("t5_tie_addr", mem_addr, 12'h155);

        // Random traffic against the reference model.
        do_reset();
        grant_t = -100; done_t = -100; d = 0; cyc = 0;
        last = 1'b1; win = 1'b0; timed = 1'b0;
        g_we = 1'b0; g_addr = '0; g_wdata = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int i = 0; i < 3000; i++) begin
            s_req0 = req0;
            s_req1 = req1;
            tick();
            cyc++;

            // A grant happens on the first edge that sees a request while idle.
            if (cyc - 1 > done_t && (s_req0 || s_req1)) begin
                win     = (s_req0 && s_req1) ? ~last : s_req1;
                last    = win;
                grant_t = cyc;
                g_we    = win ? we1 : we0;
                g_addr  = win ? addr1 : addr0;
                g_wdata = win ? wdata1 : wdata0;
                d       = $urandom_range(0, TO + 1);
                timed   = (d >= TO);
                done_t  = cyc + (timed ? TO : d + 1);
            end

            check("mem_req", mem_req, cyc >= grant_t && cyc < done_t);
            check("busy", busy, cyc >= grant_t && cyc <= done_t);
            check("ack0", ack0, cyc == done_t && !win);
            check("ack1", ack1, cyc == done_t && win);
            check("err0", err0, cyc == done_t && !win && timed);
            check("err1", err1, cyc == done_t && win && timed);
            if (cyc >= grant_t && cyc < done_t) begin
                check("owner", owner, win);
                check("mem_we", mem_we, g_we);
                check("mem_addr", mem_addr, g_addr);
                check("mem_wdata", mem_wdata, g_wdata);
            end
            if (cyc == done_t) begin
                if (timed) exp_rd[win] = '0;
                else if (!g_we) exp_rd[win] = mem_model[g_addr];
                else mem_model[g_addr] = g_wdata;
            end
            check("rdata0", rdata0, exp_rd[0]);
            check("rdata1", rdata1, exp_rd[1]);

            // Memory: respond after d cycles; late or stray pulses must be ignored.
            mem_ready = 1'b0;
            mem_rdata = DW'($urandom);
            if (cyc >= grant_t && cyc - grant_t == d) begin
                mem_ready = 1'b1;
                if (!g_we) mem_rdata = mem_model[g_addr];
            end else if (cyc >= done_t && $urandom_range(0, 9) == 0) begin
                mem_ready = 1'b1;
            end

            // Requesters: owner drops or re-requests on ack; idle ones may start.
            if (cyc == done_t) begin
                if (win) begin
                    req1 = 1'($urandom_range(0, 1));
                    if (req1) new_req(1'b1);
                end else begin
                    req0 = 1'($urandom_range(0, 1));
                    if (req0) new_req(1'b0);
                end
            end
            if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1'b1;
                new_req(1'b0);
            end
            if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1'b1;
                new_req(1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
